rs_decoder: RTL and testbench

Streaming RS(7,5) decoder over GF(8) that corrects one symbol error per codeword. It accepts 7-symbol received words one symbol per handshake, buffers them, and computes syndromes with Horner accumulation during input. It solves for a single error location and magnitude, then emits the 5 corrected message symbols on a ready/valid output. It sits at the receive end of the RS(7,5) link, opposite the encoder, and uses the same index-form symbol representation as the GF arithmetic blocks.

---
 rtl/rs_decoder.sv | 188 ++++++++++++++++++
 tb/tb_rs_decoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_decoder.sv
// Streaming RS(7,5) decoder over GF(8), single-symbol correction.
// Collects a word, solves from two syndromes, emits c6..c2.
module rs_decoder #(
  parameter int SYMBOL_WIDTH = 3,
  parameter int N = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [SYMBOL_WIDTH-1:0] out_symbol,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    out_corrected,
  output logic                    out_uncorrectable
);

  localparam int W = SYMBOL_WIDTH;

  typedef logic [W-1:0] sym_t;

  typedef enum logic [1:0] {
    COLLECT,
    SOLVE,
    EMIT
  } state_t;

  function automatic sym_t to_poly(input sym_t idx);
    sym_t p;
    unique case (idx)
      3'd0: p = 3'b000;
      3'd1: p = 3'b001;
      3'd2: p = 3'b010;
      3'd3: p = 3'b100;
      3'd4: p = 3'b011;
      3'd5: p = 3'b110;
      3'd6: p = 3'b111;
      default: p = 3'b101;
    endcase
    return p;
  endfunction

  function automatic sym_t to_idx(input sym_t p);
    sym_t idx;
    unique case (p)
      3'b000: idx = 3'd0;
      3'b001: idx = 3'd1;
      3'b010: idx = 3'd2;
      3'b100: idx = 3'd3;
      3'b011: idx = 3'd4;
      3'b110: idx = 3'd5;
      3'b111: idx = 3'd6;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

  // Multiply a polynomial-form element by alpha (x^3 = x + 1).
  function automatic sym_t mul_a(input sym_t p);
    return {p[1], p[0] ^ p[2], p[2]};
  endfunction

  function automatic sym_t mod7(input logic [4:0] v);
    logic [4:0] r;
    if (v >= 5'd14) begin
      r = v - 5'd14;
    end else if (v >= 5'd7) begin
      r = v - 5'd7;
    end else begin
      r = v;
    end
    return r[2:0];
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  beat_q, beat_d;
  sym_t        s1_q, s1_d;
  sym_t        s2_q, s2_d;
  sym_t        mem_q [N];
  sym_t        mem_d [N];
  logic        corr_q, corr_d;
  logic        unc_q, unc_d;

  sym_t        base1, base2;
  sym_t        ls1, ls2;
  sym_t        loc, e_log, e_poly;
  logic [2:0]  slot;
  sym_t        fix_sym;

  // Syndromes are kept in polynomial form; logs only for the solve.
  always_comb begin
    base1   = (cnt_q == 3'd0) ? '0 : mul_a(s1_q);
    base2   = (cnt_q == 3'd0) ? '0 : mul_a(mul_a(s2_q));
    ls1     = to_idx(s1_q) - 3'd1;
    ls2     = to_idx(s2_q) - 3'd1;
    loc     = mod7({2'b00, ls2} + 5'd7 - {2'b00, ls1});
    e_log   = mod7({1'b0, ls1, 1'b0} + 5'd7 - {2'b00, ls2});
    e_poly  = to_poly(e_log + 3'd1);
    slot    = 3'd6 - loc;
    fix_sym = to_idx(to_poly(mem_q[slot]) ^ e_poly);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    mem_d   = mem_q;
    corr_d  = corr_q;
    unc_d   = unc_q;
    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          mem_d[cnt_q] = in_symbol;
          s1_d = base1 ^ to_poly(in_symbol);
          s2_d = base2 ^ to_poly(in_symbol);
          if (cnt_q == 3'(N - 1)) begin
            cnt_d   = 3'd0;
            state_d = SOLVE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      SOLVE: begin
        corr_d  = 1'b0;
        unc_d   = 1'b0;
        beat_d  = 3'd0;
        state_d = EMIT;
        if ((s1_q == '0) != (s2_q == '0)) begin
          unc_d = 1'b1;
        end else if (s1_q != '0) begin
          corr_d      = 1'b1;
          mem_d[slot] = fix_sym;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (beat_q == 3'd4) begin
            beat_d  = 3'd0;
            state_d = COLLECT;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      beat_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      corr_q  <= 1'b0;
      unc_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    in_ready          = (state_q == COLLECT);
    out_valid         = (state_q == EMIT);
    out_symbol        = out_valid ? mem_q[beat_q] : '0;
    out_last          = out_valid && (beat_q == 3'd4);
    out_corrected     = out_valid && corr_q;
    out_uncorrectable = out_valid && unc_q;
  end

endmodule

// File: tb/tb_rs_decoder.sv
// Bench for rs_decoder: spec vectors, reset cases, and random
// words checked against a syndrome-sum reference model.
module tb_rs_decoder;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [2:0] in_symbol;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_symbol;
  logic       out_ready;
  logic       out_last;
  logic       out_corrected;
  logic       out_uncorrectable;

  int total = 0;
  int bad = 0;
  int exp_tab[7];

  rs_decoder #(.SYMBOL_WIDTH(3), .N(7)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_symbol(in_symbol),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_symbol(out_symbol),
    .out_ready(out_ready),
    .out_last(out_last),
    .out_corrected(out_corrected),
    .out_uncorrectable(out_uncorrectable)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] w[7];
    logic [2:0] m[5];
    logic       corr;
    logic       unc;
    int         stall;
    int         gap;
  } vec_t;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: act=%0d req=%0d", name, act, req);
    end
  endtask

  function automatic int poly_of(input int idx);
    return (idx == 0) ? 0 : exp_tab[idx-1];
  endfunction

  function automatic int idx_of(input int p);
    for (int k = 1; k < 8; k++) begin
      if (poly_of(k) == p) return k;
    end
    return 0;
  endfunction

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return ((a - 1) + (b - 1)) % 7 + 1;
  endfunction

  // S_j = sum_i c_i * alpha^(j*i); word slot 0 holds c6.
  function automatic int syn(input logic [2:0] w[7], input int j);
    int s = 0;
    for (int i = 0; i < 7; i++) begin
      s ^= poly_of(gmul(int'(w[6-i]), (j * i) % 7 + 1));
    end
    return s;
  endfunction

  task automatic model(input logic [2:0] w[7], output logic [2:0] m[5],
                       output logic corr, output logic unc);
    logic [2:0] r[7];
    int s1, s2, l1, l2, p, e, sl;
    r = w;
    s1 = syn(w, 1);
    s2 = syn(w, 2);
    corr = 0;
    unc = 0;
    if (s1 == 0 && s2 == 0) begin
      corr = 0;
    end else if (s1 == 0 || s2 == 0) begin
      unc = 1;
    end else begin
      l1 = idx_of(s1) - 1;
      l2 = idx_of(s2) - 1;
      p = ((l2 - l1) % 7 + 7) % 7;
      e = ((2 * l1 - l2) % 7 + 7) % 7;
      sl = 6 - p;
      r[sl] = 3'(idx_of(poly_of(int'(r[sl])) ^ exp_tab[e]));
      corr = 1;
    end
    for (int i = 0; i < 5; i++) m[i] = r[i];
  endtask

  // Called at a negedge; returns at the negedge after the 7th accept.
  task automatic send_only(input logic [2:0] w[7], input int gap);
    int n;
    for (int i = 0; i < 7; i++) begin
      if (gap > 0) begin
        n = $urandom_range(0, gap);
        repeat (n) begin
          in_valid = 0;
          in_symbol = 3'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1;
      in_symbol = w[i];
      n = 0;
      while (!in_ready && n < 30) begin
        @(negedge clk);
        n++;
      end
      if (n >= 30) chk("in_ready_wait", 0, 1);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_word(input string tag, input logic [2:0] w[7],
                          input logic [2:0] m[5], input logic ec,
                          input logic eu, input int gap, input int stall);
    int lat;
    send_only(w, gap);
    lat = 1;
    in_valid = 1;
    in_symbol = 3'($urandom);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 2);
    for (int b = 0; b < 5; b++) begin
      if (b == stall) begin
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
          chk({tag, " hold_valid"}, out_valid, 1);
          chk({tag, " hold_sym"}, out_symbol, m[b]);
          chk({tag, " hold_corr"}, out_corrected, ec);
          chk({tag, " hold_unc"}, out_uncorrectable, eu);
          @(negedge clk);
        end
      end
      out_ready = 1;
      chk({tag, " valid"}, out_valid, 1);
      chk({tag, " sym"}, out_symbol, m[b]);
      chk({tag, " last"}, out_last, (b == 4) ? 1 : 0);
      chk({tag, " corr"}, out_corrected, ec);
      chk({tag, " unc"}, out_uncorrectable, eu);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 0;
    chk({tag, " post_in_ready"}, in_ready, 1);
    chk({tag, " post_out_valid"}, out_valid, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"}, in_ready, 1);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_symbol"}, out_symbol, 0);
    chk({tag, " out_last"}, out_last, 0);
    chk({tag, " out_corr"}, out_corrected, 0);
    chk({tag, " out_unc"}, out_uncorrectable, 0);
  endtask

  vec_t vecs[5];
  logic [2:0] clean[7];
  logic [2:0] err5[7];
  logic [2:0] okmsg[5];
  logic [2:0] w[7];
  logic [2:0] em[5];
  logic       ec, eu;
  int         n;

  initial begin
    exp_tab = '{1, 2, 4, 3, 6, 7, 5};
    clean = '{1, 5, 4, 0, 0, 0, 0};
    err5  = '{1, 6, 4, 0, 0, 0, 0};
    okmsg = '{1, 5, 4, 0, 0};

    vecs[0] = '{w: clean, m: okmsg, corr: 0, unc: 0, stall: -1, gap: 0};
    vecs[1] = '{w: err5, m: okmsg, corr: 1, unc: 0, stall: 1, gap: 0};
    vecs[2] = '{w: '{1, 5, 4, 0, 0, 0, 3}, m: okmsg,
                corr: 1, unc: 0, stall: -1, gap: 2};
    vecs[3] = '{w: '{1, 5, 4, 0, 0, 1, 2}, m: okmsg,
                corr: 0, unc: 1, stall: 4, gap: 0};
    vecs[4] = '{w: '{2, 5, 4, 0, 0, 0, 0}, m: okmsg,
                corr: 1, unc: 0, stall: 0, gap: 3};

    reset = 1;
    in_valid = 0;
    in_symbol = 0;
    out_ready = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 0;
    @(negedge clk);
    chk("rst_release in_ready", in_ready, 1);

    foreach (vecs[i]) begin
      run_word($sformatf("vec%0d", i), vecs[i].w, vecs[i].m,
               vecs[i].corr, vecs[i].unc, vecs[i].gap, vecs[i].stall);
    end

    // Reset after four accepted symbols discards the partial word.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_symbol = err5[i+3];
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 0;
    reset = 1;
    @(negedge clk);
    chk_reset_vals("rst_mid_word");
    reset = 0;
    run_word("after_rst_word", clean, okmsg, 0, 0, 0, -1);

    // Reset during EMIT.
    send_only(err5, 0);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("emit_reached", out_valid, 1);
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    reset = 1;
    @(negedge clk);
    chk_reset_vals("rst_mid_emit");
    reset = 0;
    @(negedge clk);
    chk("rst_emit in_ready", in_ready, 1);
    run_word("after_rst_emit", err5, okmsg, 1, 0, 0, 2);

    // Random words with up to two symbol errors.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 5; i++) w[i] = 3'($urandom);
      w[5] = 0;
      w[6] = 0;
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          logic [2:0] c[7];
          c = w;
          c[5] = 3'(a);
          c[6] = 3'(b);
          if (syn(c, 1) == 0 && syn(c, 2) == 0) w = c;
        end
      end
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        int pos;
        pos = $urandom_range(0, 6);
        w[pos] = 3'(idx_of(poly_of(int'(w[pos])) ^ $urandom_range(1, 7)));
      end
      model(w, em, ec, eu);
      n = $urandom_range(0, 5);
      run_word($sformatf("rnd%0d", t), w, em, ec, eu,
               $urandom_range(0, 2), (n == 5) ? -1 : n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
